buf_write_arbiter: RTL and testbench
====================================

Name: buf_write_arbiter

Overview:
Round-robin arbiter that shares the single 16-bit write port of the team's word buffer among N_REQ producers. Grants one producer at a time for a bounded burst of writes and stalls on buffer_full. Drives the buffer's data/enable write inputs directly. Single clock domain, on the buffer's write-side clock.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 16, word width; matches buffer width
MAX_BURST, 4, max words accepted per grant (1..15)

Ports:
clk  input  1  write-side clock
rst  input  1  asynchronous reset, active-low; 0 resets all state
req  input  N_REQ  per-requester request; held high while a word is pending
req_data  input  N_REQ*DATA_W  flat data bus; requester i on bits [i*DATA_W +: DATA_W]
buffer_full  input  1  buffer full flag; no write is issued while 1
ack  output  N_REQ  per-requester accept strobe; word taken on the clk edge where ack[i]=1
gnt  output  N_REQ  registered one-hot grant (0 when idle)
wr_en  output  1  write enable to buffer
wr_data  output  DATA_W  write data to buffer
busy  output  1  1 while in BURST state

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0, gnt=0, burst_cnt=0. wr_en=0, ack=0, wr_data=0, busy=0 immediately.
- rr_ptr: index of the highest-priority requester for the next arbitration, width clog2(N_REQ).
- State IDLE:
  - No writes. wr_en=0, ack=0, wr_data=0.
  - If any req bit is high at a clk edge, select the first set bit scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - On that edge: gnt=onehot(sel), burst_cnt=0, state=BURST.
  - Otherwise stay in IDLE.
- State BURST (g = granted index):
  - wr_en = req[g] & ~buffer_full. This is combinational, with zero latency from req/full.
  - ack[g] = wr_en. All other ack bits are 0.
  - wr_data = req_data[g] when wr_en=1, else 0.
  - Each clk edge with wr_en=1 increments burst_cnt.
  - buffer_full=1 freezes the burst: grant held, burst_cnt held, no timeout.
  - Exit to IDLE on the clk edge where either:
    a) req[g]=0 (requester released, no write that cycle), or
    b) wr_en=1 and burst_cnt==MAX_BURST-1 (last allowed word written).
  - On exit: gnt=0, rr_ptr=(g+1) mod N_REQ, burst_cnt=0.
- Latency:
  - req rise at edge k is sampled; gnt is visible after edge k.
  - First write is accepted at edge k+1 if buffer_full=0.
  - One mandatory IDLE cycle separates consecutive grants, even to the same requester.
- Requester contract:
  - req_data[i] stays stable while req[i]=1 and ack[i]=0.
  - Dropping req before ack abandons the word; the arbiter never writes it.
- Fairness: after any grant, the granted index becomes lowest priority, so no starvation.
- Requests from non-granted requesters are ignored until the next IDLE arbitration.
- Simultaneous req drop and buffer_full=1 in BURST: case a) applies and the FSM exits.
- rr_ptr wraps from N_REQ-1 to 0.
- Reset asserted mid-burst:
  - All outputs go to 0 immediately.
  - The in-flight word is not written.
  - After release, arbitration restarts with rr_ptr=0.

Test Plan:
- Single requester:
  - Stimulus: req[0]=1 for 6 words, data 0x0001..0x0006, buffer_full=0, MAX_BURST=4.
  - Response: writes 0x0001..0x0004 on 4 consecutive edges; 1 IDLE cycle; re-grant; writes 0x0005, 0x0006; gnt returns to 0 after req[0] drops.
- Round-robin:
  - Stimulus: req[0], req[2] held continuously after reset, distinct data per requester.
  - Response: grant order 0,2,0,2; 4 words per grant; 1 idle cycle between grants.
- Full stall:
  - Stimulus: during a burst from requester 1, buffer_full=1 for 3 cycles after the 2nd word.
  - Response: wr_en=0 and ack=0 for 3 cycles, gnt stays 0010, burst resumes with word 3, burst ends after word 4.
- Pointer wrap:
  - Stimulus: only req[3]=1 for one word, then req[0] and req[3] both high.
  - Response: requester 3 is granted first; next grant goes to requester 0 (rr_ptr wrapped to 0).
- Early release:
  - Stimulus: requester 2 granted; req[2] drops after 1 word while req[1]=1.
  - Response: exit after the drop edge; 1 idle cycle; gnt=0010 (requester 1); rr_ptr was 3 and scans 3,0,1.
- Reset mid-burst:
  - Stimulus: rst=0 asynchronously between edges during the 2nd word of a burst.
  - Response: wr_en, ack, gnt, busy=0 immediately; after release with req[1]=1 and req[0]=1, requester 0 is granted first.

Source files
------------

// File: rtl/buf_write_arbiter.sv
// Round-robin arbiter sharing one buffer write port among N_REQ producers.
// Grants bounded bursts, stalls on buffer_full, one idle cycle between grants.
module buf_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    buffer_full,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        gnt,
  output logic                    wr_en,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    busy
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    rr_ptr, rr_nx;
  logic [PW-1:0]    g_idx, g_nx;
  logic [PW-1:0]    sel;
  logic [N_REQ-1:0] gnt_nx;
  logic [3:0]       cnt, cnt_nx;
  logic             found;
  logic             done;

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % N_REQ]) begin
        found = 1'b1;
        sel   = PW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    busy    = (state == BURST);
    wr_en   = busy & req[g_idx] & ~buffer_full;
    ack     = '0;
    wr_data = '0;
    if (wr_en) begin
      ack[g_idx] = 1'b1;
      wr_data    = req_data[int'(g_idx)*DATA_W +: DATA_W];
    end
  end

  assign done = ~req[g_idx] | (wr_en & (cnt == LAST));

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    g_nx     = g_idx;
    gnt_nx   = gnt;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx = BURST;
          g_nx     = sel;
          gnt_nx   = N_REQ'(1) << sel;
          cnt_nx   = '0;
        end
      end
      BURST: begin
        if (done) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          cnt_nx   = '0;
          rr_nx    = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
        end else if (wr_en) begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      g_idx  <= '0;
      gnt    <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_nx;
      g_idx  <= g_nx;
      gnt    <= gnt_nx;
      cnt    <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_buf_write_arbiter.sv
// Bench for buf_write_arbiter: producer queues drive requests and a
// grant/word-count reference model predicts every output each cycle.
module tb_buf_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           full;
  logic [N-1:0]   ack;
  logic [N-1:0]   gnt;
  logic           wr_en;
  logic [W-1:0]   wr_data;
  logic           busy;

  buf_write_arbiter #(
    .N_REQ(N), .DATA_W(W), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .buffer_full(full), .ack(ack), .gnt(gnt), .wr_en(wr_en),
    .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int owner  = -1;
  int cnt    = 0;
  int ptr    = 0;
  logic [W-1:0] q [N][$];
  logic [W-1:0] wlog [$];
  int           glog [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = (q[i].size() > 0);
      req_data[i*W +: W] = req[i] ? q[i][0] : '0;
    end
  endtask

  task automatic check_outs();
    logic          en;
    logic [N-1:0]  eg;
    logic [W-1:0]  ed;
    en = (owner >= 0) && (q[owner].size() > 0) && !full;
    eg = (owner >= 0) ? N'(1) << owner : '0;
    ed = en ? q[owner][0] : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(owner >= 0));
    chk("wr_en", 32'(wr_en), 32'(en));
    chk("ack", 32'(ack), en ? 32'(eg) : 32'd0);
    chk("wr_data", 32'(wr_data), 32'(ed));
  endtask

  task automatic model_edge();
    if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && q[(ptr + k) % N].size() > 0) begin
          owner = (ptr + k) % N;
          cnt   = 0;
          glog.push_back(owner);
        end
      end
    end else if (q[owner].size() == 0) begin
      ptr   = (owner + 1) % N;
      owner = -1;
    end else if (!full) begin
      wlog.push_back(q[owner].pop_front());
      cnt++;
      if (cnt == MB) begin
        ptr   = (owner + 1) % N;
        owner = -1;
      end
    end
  endtask

  task automatic step(input logic f);
    full = f;
    drive();
    #1 check_outs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    rst   = 1'b0;
    full  = 1'b0;
    owner = -1;
    cnt   = 0;
    ptr   = 0;
    drive();
    #1 check_outs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wlog.delete();
    glog.delete();
  endtask

  initial begin
    req      = '0;
    req_data = '0;
    full     = 1'b0;
    do_reset();

    // single requester, 6 words, MAX_BURST 4
    for (int i = 1; i <= 6; i++) q[0].push_back(W'(i));
    for (int s = 0; s < 12; s++) step(1'b0);
    chk("single_cnt", wlog.size(), 6);
    for (int i = 0; i < wlog.size(); i++)
      chk("single_word", 32'(wlog[i]), i + 1);
    chk("single_grants", glog.size(), 2);

    // round robin between 0 and 2
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q[0].push_back(W'(16'h1000 + i));
      q[2].push_back(W'(16'h2000 + i));
    end
    for (int s = 0; s < 20; s++) step(1'b0);
    chk("rr_cnt", glog.size(), 4);
    for (int i = 0; i < glog.size(); i++)
      chk("rr_order", glog[i], (i % 2) * 2);
    chk("rr_words", wlog.size(), 16);

    // full stall in the middle of a burst from requester 1
    do_reset();
    for (int i = 0; i < 4; i++) q[1].push_back(W'(16'h0A00 + i));
    step(1'b0);
    step(1'b0);
    step(1'b0);
    for (int s = 0; s < 3; s++) step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("stall_words", wlog.size(), 4);
    chk("stall_gnt_end", 32'(gnt), 0);

    // pointer wrap
    do_reset();
    q[3].push_back(16'h3333);
    for (int s = 0; s < 3; s++) step(1'b0);
    q[0].push_back(16'h0C00);
    q[3].push_back(16'h3C00);
    for (int s = 0; s < 8; s++) step(1'b0);
    chk("wrap_cnt", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("wrap_first", glog[0], 3);
      chk("wrap_second", glog[1], 0);
    end

    // early release of requester 2 while 1 waits
    do_reset();
    for (int i = 0; i < 3; i++) q[2].push_back(W'(16'h2200 + i));
    step(1'b0);
    q[1].push_back(16'h1100);
    q[1].push_back(16'h1101);
    step(1'b0);
    q[2].delete();
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("early_gnt", 32'(gnt), 32'h2);
    chk("early_cnt", glog.size(), 2);
    if (glog.size() == 2) chk("early_second", glog[1], 1);

    // asynchronous reset during the second word of a burst
    do_reset();
    for (int i = 0; i < 3; i++) q[1].push_back(W'(16'h0B00 + i));
    step(1'b0);
    step(1'b0);
    drive();
    #2 rst = 1'b0;
    owner = -1;
    cnt   = 0;
    ptr   = 0;
    #1 check_outs();
    @(posedge clk);
    @(negedge clk);
    chk("rst_words", wlog.size(), 1);
    q[0].push_back(16'h0D00);
    glog.delete();
    rst = 1'b1;
    for (int s = 0; s < 8; s++) step(1'b0);
    chk("rst_cnt", glog.size(), 2);
    if (glog.size() > 0) chk("rst_first", glog[0], 0);

    // randomized traffic, stalls and abandons
    do_reset();
    for (int s = 0; s < 600; s++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0 && q[i].size() < 6)
          q[i].push_back(W'($urandom));
        if ($urandom_range(0, 19) == 0)
          q[i].delete();
      end
      step($urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
